// File: rtl/fcvtsw_pipe.sv
// Signed int32 to IEEE-754 single converter (fcvt.s.w), two-stage elastic pipeline.
// Latency 2 cycles from accept to out_valid; throughput 1/cycle; capacity 2 in flight.
// Backpressure: y/inexact hold while out_valid && !out_ready; in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready/x  operand handshake, x sampled only on a transfer
//   out_valid/out_ready  result handshake
//   y, inexact           float result and lost-bits flag
// Build option: define FCVTSW_RNE_EN for round-to-nearest-even; otherwise round toward zero.
module fcvtsw_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        inexact
);

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  lzc;
    logic        zero;
  } s1_t;

  s1_t         s1_d;
  s1_t         s1_q;
  logic        s1_valid;
  logic        in_fire;
  logic        s2_load;

  logic [31:0] mag_c;
  logic [30:0] norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic [7:0]  expo;
  logic [30:0] em;
  logic [31:0] y_d;
  logic        inexact_d;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // Stage 1: magnitude (unsigned, so -2^31 maps to 0x80000000) and leading-zero count.
  always_comb begin
    s1_d      = '0;
    mag_c     = x[31] ? (~x + 32'd1) : x;
    s1_d.sign = x[31];
    s1_d.mag  = mag_c;
    s1_d.zero = (x == 32'd0);
    s1_d.lzc  = 5'd31;
    // Highest set bit wins because later iterations overwrite earlier ones.
    for (int i = 0; i < 32; i++) begin
      if (mag_c[i]) s1_d.lzc = 5'(31 - i);
    end
  end

  // Stage 2: normalise; the leading one lands in bit 31 and is implicit, so drop it.
  assign norm   = 31'(s1_q.mag << s1_q.lzc);
  assign mant   = norm[30:8];
  assign guard  = norm[7];
  assign sticky = |norm[6:0];
  assign expo   = 8'd158 - {3'b000, s1_q.lzc};

`ifdef FCVTSW_RNE_EN
  logic up;
  assign up = guard && (sticky || mant[0]);
  // A mantissa carry-out ripples into the exponent; the largest case is exactly 2^31.
  assign em = {expo, mant} + 31'(up);
`else
  assign em = {expo, mant};
`endif

  assign y_d       = s1_q.zero ? 32'd0 : {s1_q.sign, em};
  assign inexact_d = !s1_q.zero && (guard || sticky);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      inexact   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        y         <= y_d;
        inexact   <= inexact_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fcvtsw_pipe.sv
// Self-checking bench for fcvtsw_pipe: directed values, backpressure, reset mid-flight, random sweep.
module tb_fcvtsw_pipe;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        inexact;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [32:0] sb[$];
  int          acc_q[$];
  bit          lat_chk   = 0;
  bit          rand_mode = 0;
  bit          hold_vld  = 0;
  logic [32:0] hold_val;

  fcvtsw_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion by explicit quotient/remainder rounding.
  function automatic logic [32:0] ref_cvt(input logic [31:0] v);
    logic        s;
    logic [31:0] a;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    int          p;
    int          sh;
    if (v == 32'd0) return 33'd0;
    s = v[31];
    a = s ? (32'd0 - v) : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (a[i]) p = i;
    rem = 64'd0;
    if (p <= 23) begin
      q = 64'(a) << (23 - p);
    end else begin
      sh   = p - 23;
      q    = 64'(a) >> sh;
      rem  = 64'(a) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
`ifdef FCVTSW_RNE_EN
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
`endif
    end
    return {s, 8'(127 + p), q[22:0], rem != 64'd0};
  endfunction

  // Output monitor: scoreboard pop, optional latency check, hold-stable check under stall.
  always @(negedge clk) begin
    logic [32:0] e;
    int          a;
    if (!rstn) begin
      hold_vld = 0;
    end else begin
      if (hold_vld && out_valid) begin
        tests++;
        assert ({y, inexact} === hold_val)
        else begin
          fails++;
          $error("FAIL hold_stable: got %h/%b want %h/%b", y, inexact, hold_val[32:1], hold_val[0]);
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_val = {y, inexact};
      if (out_valid && out_ready) begin
        tests++;
        assert (sb.size() != 0)
        else begin
          fails++;
          $error("FAIL unexpected_output: got y=%h with empty scoreboard, want no output", y);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          tests++;
          assert ({y, inexact} === e)
          else begin
            fails++;
            $error("FAIL result: got y=%h inexact=%b want y=%h inexact=%b", y, inexact, e[32:1], e[0]);
          end
          if (lat_chk) begin
            tests++;
            assert (cyc - a == 2)
            else begin
              fails++;
              $error("FAIL latency: got %0d cycles want 2", cyc - a);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [32:0] e);
    int n;
    bit done;
    n    = 0;
    done = 0;
    in_valid = 1'b1;
    x        = v;
    while (!done && n <= 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        acc_q.push_back(cyc);
        done = 1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom);
    end
    in_valid = 1'b0;
    tests++;
    assert (done)
    else begin
      fails++;
      $error("FAIL send_timeout: operand %h not accepted, want accept within 200 cycles", v);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      x = $urandom;
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 32'd0;

    // Reset state
    #12;
    tests++;
    assert (out_valid === 1'b0 && y === 32'd0 && inexact === 1'b0)
    else begin
      fails++;
      $error("FAIL reset_outputs: got v=%b y=%h i=%b want 0/0/0", out_valid, y, inexact);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    tests++;
    assert (in_ready === 1'b1)
    else begin
      fails++;
      $error("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;

    // Basic and extreme values, back-to-back with latency checked
    lat_chk = 1;
    send(32'd1,          {32'h3F800000, 1'b0});
    send(32'hFFFFFFFF,   {32'hBF800000, 1'b0});
    send(32'd0,          {32'h00000000, 1'b0});
    send(32'h80000000,   {32'hCF000000, 1'b0});
`ifdef FCVTSW_RNE_EN
    send(32'h7FFFFFFF,   {32'h4F000000, 1'b1});
    send(32'd16777217,   {32'h4B800000, 1'b1});
    send(32'd16777219,   {32'h4B800002, 1'b1});
`else
    send(32'h7FFFFFFF,   {32'h4EFFFFFF, 1'b1});
    send(32'd16777217,   {32'h4B800000, 1'b1});
    send(32'd16777219,   {32'h4B800001, 1'b1});
`endif
    send(32'd100,        {32'h42C80000, 1'b0});
    drain();
    lat_chk = 0;

    // Backpressure: two accepted, third blocked, outputs stable
    out_ready = 1'b0;
    send(32'd2,          {32'h40000000, 1'b0});
    send(32'd3,          {32'h40400000, 1'b0});
    in_valid = 1'b1;
    x        = 32'hFFFFFFF8;
    repeat (3) begin
      @(negedge clk);
      tests++;
      assert (in_ready === 1'b0 && out_valid === 1'b1 && y === 32'h40000000)
      else begin
        fails++;
        $error("FAIL backpressure: got rdy=%b v=%b y=%h want 0/1/40000000", in_ready, out_valid, y);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'hFFFFFFF8,   {32'hC1000000, 1'b0});
    drain();

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(32'd5,          {32'h40A00000, 1'b0});
    send(32'd7,          {32'h40E00000, 1'b0});
    #2 rstn = 1'b0;
    #1;
    tests++;
    assert (out_valid === 1'b0 && y === 32'd0 && inexact === 1'b0)
    else begin
      fails++;
      $error("FAIL reset_midflight: got v=%b y=%h i=%b want 0/0/0", out_valid, y, inexact);
    end
    sb.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests++;
      assert (out_valid === 1'b0 && in_ready === 1'b1)
      else begin
        fails++;
        $error("FAIL post_reset: got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;

    // Random sweep with random in_valid gaps and out_ready
    rand_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      idle(int'($urandom_range(0, 2)));
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 255) - 128;
        1:       v = 32'(($urandom_range(0, 8388607)) + 16777216) << $urandom_range(0, 7);
        default: v = $urandom;
      endcase
      send(v, ref_cvt(v));
    end
    rand_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
